ddr3_pwrup_seq: RTL and testbench
=================================

# ddr3_pwrup_seq

Power-up and reset sequencer sitting directly downstream of the DDR3 clock PLL. It runs on the PLL's divided clock and consumes the PLL `lock` flag. Once lock has been stable for a programmed interval, it drives the JEDEC DDR3 power-up sequence: RESET# low ≥200 µs, then CKE low ≥500 µs. It then hands off to the DDR3 controller's init engine through a req/ack handshake, and holds the controller in reset whenever the PLL is unlocked.

## Interface
Parameters:
- `CLK_MHZ`, 100: `clk` frequency in MHz (integer); used only to convert µs to cycles.
- `LOCK_STABLE_CYC`, 1024: consecutive cycles of synchronized lock required before sequencing starts.
- `T_RESET_US`, 200: duration for which `ddr_reset_n` is held low.
- `T_CKE_US`, 500: wait from `ddr_reset_n` rising to `ddr_cke` rising.
- `INIT_TIMEOUT_CYC`, 65536: maximum cycles `init_req` stays high waiting for `init_ack` before the sequence restarts.

Ports:
- `clk`, in, 1: divided PLL clock (`clkoutd`, ≈100 MHz).
- `resetn`, in, 1: synchronous, active-low reset.
- `pll_lock`, in, 1: PLL lock; asynchronous to `clk`.
- `ddr_reset_n`, out, 1: DDR3 RESET# pin drive.
- `ddr_cke`, out, 1: DDR3 CKE pin drive.
- `ctrl_rst_n`, out, 1: active-low reset to the DDR3 controller.
- `init_req`, out, 1: request to the controller to run MRS/ZQCL init.
- `init_ack`, in, 1: one-cycle pulse from the controller when init is complete.
- `ready`, out, 1: memory is usable.
- `restart_cnt`, out, 8: count of sequence aborts (lock loss or init timeout); saturates at 255.

## Operation
- `pll_lock` passes through a 2-flop synchronizer; `lock_s` is the synchronizer output.
- Derived constants:
  - `T_RESET_CYC` = `T_RESET_US`*`CLK_MHZ`
  - `T_CKE_CYC` = `T_CKE_US`*`CLK_MHZ`
  - One shared counter, width = `$clog2` of the largest of all cycle constants.
- Each state is entered at cycle t with the counter at 0. A timed state of length N exits when counter == N−1, so the next state begins at t+N.
- States and transitions:
  - WAIT_LOCK: go to STABLE when `lock_s`=1.
  - STABLE: go to WAIT_LOCK if `lock_s`=0 (counter clears). After `LOCK_STABLE_CYC` cycles, go to RST_LOW.
  - RST_LOW: go to CKE_WAIT after `T_RESET_CYC` cycles.
  - CKE_WAIT: go to INIT after `T_CKE_CYC` cycles.
  - INIT: go to READY on `init_ack`=1. If the counter reaches `INIT_TIMEOUT_CYC`−1 with no ack, go to RST_LOW (abort).
  - READY: terminal state while locked.
- Lock loss: in RST_LOW, CKE_WAIT, INIT or READY, `lock_s`=0 takes priority over every other condition. The block goes to WAIT_LOCK next cycle and counts an abort.
- Outputs are a direct decode of the state register, with no added latency:
  - `ddr_reset_n` = 1 in CKE_WAIT, INIT and READY.
  - `ddr_cke` = 1 in INIT and READY.
  - `ctrl_rst_n` = 1 in CKE_WAIT, INIT and READY.
  - `init_req` = 1 in INIT only.
  - `ready` = 1 in READY only.
- `init_ack` is ignored outside INIT.
- `init_ack` arriving in the same cycle as the timeout cycle counts as success: go to READY.
- `restart_cnt` increments by 1 per abort. It clears only on `resetn`.

## Timing
- `resetn`=0 forces, on the next edge:
  - state = WAIT_LOCK
  - counter = 0
  - synchronizer flops = 0
  - `restart_cnt` = 0
  - all outputs = 0, including `ddr_reset_n` and `ddr_cke`
- Reset applies mid-sequence with no exceptions.
- Latency from `pll_lock` rising to entering STABLE is 3 cycles: 2 synchronizer flops plus the state register.
- Cycles from `lock_s` rising to `ddr_reset_n` rising = 1 + `LOCK_STABLE_CYC` + `T_RESET_CYC`.
- `ddr_cke` rises exactly `T_CKE_CYC` cycles after `ddr_reset_n` rises.
- `init_req` rises in the same cycle as `ddr_cke`. It falls, and `ready` rises, on the cycle after the `init_ack` pulse.
- A 1-cycle glitch low of `lock_s` in STABLE restarts the full `LOCK_STABLE_CYC` window.

## Structure
- Package `ddr3_pkg`:
  - state enum `pwrup_state_t` (WAIT_LOCK, STABLE, RST_LOW, CKE_WAIT, INIT, READY)
  - constant function converting µs to cycles
- Sub-module `sync2`: a 2-flop synchronizer, reusable elsewhere in the design.
- Everything else is one FSM plus one counter, in a single module.

## Test plan
Unless noted, parameters are `CLK_MHZ`=1, `LOCK_STABLE_CYC`=16, `T_RESET_US`=20, `T_CKE_US`=50, `INIT_TIMEOUT_CYC`=100.
- Nominal sequence:
  - Stimulus: `pll_lock` rises at cycle 10; `init_ack` pulses 5 cycles after `init_req` rises.
  - Response: `ddr_reset_n` rises at cycle 10+3+16+20=49; `ddr_cke` and `init_req` rise at 99; `ready` rises at 105; `restart_cnt`=0.
- Lock glitch:
  - Stimulus: `pll_lock` drops for 1 cycle 8 cycles into STABLE.
  - Response: the STABLE window restarts; `ddr_reset_n` rises 16+20 cycles after lock returns plus synchronizer latency; `restart_cnt` stays 0.
- Init timeout:
  - Stimulus: no `init_ack` is ever sent.
  - Response: after 100 cycles `init_req` falls; `ddr_reset_n` and `ddr_cke` return to 0 for 20 cycles; `restart_cnt`=1; INIT is re-entered 70 cycles later.
- Lock loss in READY:
  - Stimulus: `pll_lock` drops.
  - Response: 3 cycles later `ready`, `ddr_cke`, `ddr_reset_n` and `ctrl_rst_n` are all 0; `restart_cnt` increments.
- Sync reset mid-CKE_WAIT:
  - Stimulus: `resetn`=0 for 1 cycle.
  - Response: all outputs are 0 on the next edge and `restart_cnt`=0; the sequence restarts from WAIT_LOCK.
- Ack coincident with timeout:
  - Stimulus: `init_ack` arrives in cycle 99 of INIT.
  - Response: `ready`=1 and no abort is counted.

Source files
------------

// File: rtl/ddr3_pkg.sv
// Shared types and helpers for the DDR3 power-up sequencer.
package ddr3_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RST_LOW   = 3'd2,
        CKE_WAIT  = 3'd3,
        INIT      = 3'd4,
        READY     = 3'd5
    } pwrup_state_t;

    function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned clk_mhz);
        return us * clk_mhz;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
module sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/ddr3_pwrup_seq.sv
// DDR3 power-up sequencer: waits for stable PLL lock, times RESET#/CKE,
// then hands off to the controller init engine via req/ack.
module ddr3_pwrup_seq
    import ddr3_pkg::*;
#(
    parameter int unsigned CLK_MHZ          = 32'd100,
    parameter int unsigned LOCK_STABLE_CYC  = 32'd1024,
    parameter int unsigned T_RESET_US       = 32'd200,
    parameter int unsigned T_CKE_US         = 32'd500,
    parameter int unsigned INIT_TIMEOUT_CYC = 32'd65536
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    output logic       ddr_reset_n,
    output logic       ddr_cke,
    output logic       ctrl_rst_n,
    output logic       init_req,
    input  logic       init_ack,
    output logic       ready,
    output logic [7:0] restart_cnt
);

    localparam int unsigned T_RESET_CYC = us_to_cyc(T_RESET_US, CLK_MHZ);
    localparam int unsigned T_CKE_CYC   = us_to_cyc(T_CKE_US, CLK_MHZ);
    localparam int unsigned MAX_CYC     = max_u(max_u(LOCK_STABLE_CYC, T_RESET_CYC),
                                                max_u(T_CKE_CYC, INIT_TIMEOUT_CYC));
    localparam int unsigned CNT_W       = (MAX_CYC > 32'd1) ? $clog2(MAX_CYC) : 32'd1;

    localparam logic [CNT_W-1:0] LOCK_END    = CNT_W'(LOCK_STABLE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] RESET_END   = CNT_W'(T_RESET_CYC - 32'd1);
    localparam logic [CNT_W-1:0] CKE_END     = CNT_W'(T_CKE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] TIMEOUT_END = CNT_W'(INIT_TIMEOUT_CYC - 32'd1);

    pwrup_state_t     r_state;
    pwrup_state_t     w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_lock_s;
    logic             w_abort;
    logic [7:0]       r_restart_cnt;
    logic             r_ddr_reset_n;
    logic             r_ddr_cke;
    logic             r_ctrl_rst_n;
    logic             r_init_req;
    logic             r_ready;
    logic             w_ddr_reset_n;
    logic             w_ddr_cke;
    logic             w_ctrl_rst_n;
    logic             w_init_req;
    logic             w_ready;

    sync2 u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .i_d    (pll_lock),
        .o_q    (w_lock_s)
    );

    // Next-state logic; lock loss past STABLE overrides everything and counts as an abort
    always_comb begin
        w_next_state = r_state;
        w_abort      = 1'b0;
        case (r_state)
            WAIT_LOCK: begin
                if (w_lock_s) w_next_state = STABLE;
                else          w_next_state = WAIT_LOCK;
            end
            STABLE: begin
                if (!w_lock_s)              w_next_state = WAIT_LOCK;
                else if (r_cnt == LOCK_END) w_next_state = RST_LOW;
                else                        w_next_state = STABLE;
            end
            RST_LOW: begin
                if (!w_lock_s) begin
                    w_next_state = WAIT_LOCK;
                    w_abort      = 1'b1;
                end else if (r_cnt == RESET_END) begin
                    w_next_state = CKE_WAIT;
                end else begin
                    w_next_state = RST_LOW;
                end
            end
            CKE_WAIT: begin
                if (!w_lock_s) begin
                    w_next_state = WAIT_LOCK;
                    w_abort      = 1'b1;
                end else if (r_cnt == CKE_END) begin
                    w_next_state = INIT;
                end else begin
                    w_next_state = CKE_WAIT;
                end
            end
            INIT: begin
                if (!w_lock_s) begin
                    w_next_state = WAIT_LOCK;
                    w_abort      = 1'b1;
                end else if (init_ack) begin
                    w_next_state = READY;
                end else if (r_cnt == TIMEOUT_END) begin
                    w_next_state = RST_LOW;
                    w_abort      = 1'b1;
                end else begin
                    w_next_state = INIT;
                end
            end
            READY: begin
                if (!w_lock_s) begin
                    w_next_state = WAIT_LOCK;
                    w_abort      = 1'b1;
                end else begin
                    w_next_state = READY;
                end
            end
            default: begin
                w_next_state = WAIT_LOCK;
            end
        endcase
    end

    // Counter restarts on every state change; untimed states hold it at zero
    always_comb begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if ((w_next_state != r_state) || (r_state == WAIT_LOCK) || (r_state == READY)) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // Output decode of the upcoming state so the registered pins track the state register
    always_comb begin
        w_ddr_reset_n = 1'b0;
        w_ddr_cke     = 1'b0;
        w_ctrl_rst_n  = 1'b0;
        w_init_req    = 1'b0;
        w_ready       = 1'b0;
        case (w_next_state)
            CKE_WAIT: begin
                w_ddr_reset_n = 1'b1;
                w_ctrl_rst_n  = 1'b1;
            end
            INIT: begin
                w_ddr_reset_n = 1'b1;
                w_ddr_cke     = 1'b1;
                w_ctrl_rst_n  = 1'b1;
                w_init_req    = 1'b1;
            end
            READY: begin
                w_ddr_reset_n = 1'b1;
                w_ddr_cke     = 1'b1;
                w_ctrl_rst_n  = 1'b1;
                w_ready       = 1'b1;
            end
            default: begin
                w_ddr_reset_n = 1'b0;
            end
        endcase
    end

    // State, counter, outputs and saturating abort count
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= WAIT_LOCK;
            r_cnt         <= {CNT_W{1'b0}};
            r_restart_cnt <= 8'd0;
            r_ddr_reset_n <= 1'b0;
            r_ddr_cke     <= 1'b0;
            r_ctrl_rst_n  <= 1'b0;
            r_init_req    <= 1'b0;
            r_ready       <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_cnt_next;
            r_ddr_reset_n <= w_ddr_reset_n;
            r_ddr_cke     <= w_ddr_cke;
            r_ctrl_rst_n  <= w_ctrl_rst_n;
            r_init_req    <= w_init_req;
            r_ready       <= w_ready;
            if (w_abort && (r_restart_cnt != 8'hFF)) begin
                r_restart_cnt <= r_restart_cnt + 8'd1;
            end else begin
                r_restart_cnt <= r_restart_cnt;
            end
        end
    end

    assign ddr_reset_n = r_ddr_reset_n;
    assign ddr_cke     = r_ddr_cke;
    assign ctrl_rst_n  = r_ctrl_rst_n;
    assign init_req    = r_init_req;
    assign ready       = r_ready;
    assign restart_cnt = r_restart_cnt;

endmodule

// File: tb/tb_ddr3_pwrup_seq.sv
// Scoreboard bench: stimulus tasks predict each output change (cycle and value)
// from the sequencing rules; a monitor compares every observed change in order.
module tb_ddr3_pwrup_seq;

    localparam int LS = 16;
    localparam int TR = 20;
    localparam int TC = 50;
    localparam int TO = 100;
    // {ddr_reset_n, ddr_cke, ctrl_rst_n, init_req, ready}
    localparam logic [4:0] O_NONE  = 5'b00000;
    localparam logic [4:0] O_CKEW  = 5'b10100;
    localparam logic [4:0] O_INIT  = 5'b11110;
    localparam logic [4:0] O_READY = 5'b11101;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_lock;
    logic       init_ack;
    logic       ddr_reset_n;
    logic       ddr_cke;
    logic       ctrl_rst_n;
    logic       init_req;
    logic       ready;
    logic [7:0] restart_cnt;

    typedef struct {
        int          cyc;
        logic [12:0] vec;
    } ev_t;

    ev_t         exp_q[$];
    logic [12:0] exp_last;
    logic [7:0]  m_rc;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          done = 1'b0;

    ddr3_pwrup_seq #(
        .CLK_MHZ          (1),
        .LOCK_STABLE_CYC  (LS),
        .T_RESET_US       (TR),
        .T_CKE_US         (TC),
        .INIT_TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pll_lock    (pll_lock),
        .ddr_reset_n (ddr_reset_n),
        .ddr_cke     (ddr_cke),
        .ctrl_rst_n  (ctrl_rst_n),
        .init_req    (init_req),
        .init_ack    (init_ack),
        .ready       (ready),
        .restart_cnt (restart_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [12:0] outs();
        return {ddr_reset_n, ddr_cke, ctrl_rst_n, init_req, ready, restart_cnt};
    endfunction

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input int c, input logic [4:0] o);
        ev_t e;
        logic [12:0] v;
        v = {o, m_rc};
        if (v != exp_last) begin
            e.cyc = c;
            e.vec = v;
            exp_q.push_back(e);
            exp_last = v;
        end
    endtask

    task automatic abort_cnt();
        if (m_rc != 8'd255) m_rc = m_rc + 8'd1;
    endtask

    task automatic check_now(input string name, input logic [12:0] got, input logic [12:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    // Lock visible to the DUT after edge p: STABLE from p+3, CKE_WAIT p+3+LS+TR, INIT +TC
    task automatic start_lock(input int p);
        go_to(p);
        pll_lock = 1'b1;
    endtask

    task automatic ack_at(input int i, input int k);
        go_to(i + k - 1);
        init_ack = 1'b1;
        push_ev(i + k, O_READY);
        go_to(i + k);
        init_ack = 1'b0;
    endtask

    task automatic drop_lock(input bit counts);
        int d;
        d = cyc;
        pll_lock = 1'b0;
        if (counts) abort_cnt();
        push_ev(d + 3, O_NONE);
        go_to(d + 3);
    endtask

    task automatic full_up(input int p, input int k);
        int i;
        i = p + 3 + LS + TR + TC;
        push_ev(p + 3 + LS + TR, O_CKEW);
        push_ev(i, O_INIT);
        go_to(p + 59);
        init_ack = 1'b1;
        go_to(p + 60);
        init_ack = 1'b0;
        ack_at(i, k);
    endtask

    task automatic reset_dut(input bit keep_lock, output int p);
        int n;
        n = cyc;
        resetn = 1'b0;
        init_ack = 1'b0;
        if (!keep_lock) pll_lock = 1'b0;
        m_rc = 8'd0;
        push_ev(n + 1, O_NONE);
        go_to(n + 2);
        resetn = 1'b1;
        p = n + 2;
    endtask

    task automatic monitor();
        logic [12:0] prev;
        logic [12:0] cur;
        ev_t e;
        prev = 13'd0;
        while (!done) begin
            @(negedge clk);
            cur = outs();
            if (cur !== prev) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_change cyc=%0d got=%b want=no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.cyc != cyc) || (e.vec !== cur)) begin
                        n_fail++;
                        $display("FAIL out_event cyc=%0d got=%b want cyc=%0d vec=%b",
                                 cyc, cur, e.cyc, e.vec);
                    end
                end
                prev = cur;
            end
        end
    endtask

    task automatic stimulus();
        int p, i, k, kind, nto, g;
        // nominal: lock at cycle ~10, ack 5 cycles after init_req, then lock loss in READY
        start_lock(cyc + 8);
        full_up(cyc, 5);
        go_to(cyc + $urandom_range(1, 10));
        drop_lock(1'b1);
        for (int n = 0; n < 12; n++) begin
            p = cyc + $urandom_range(1, 6);
            start_lock(p);
            kind = (n < 5) ? n : $urandom_range(0, 4);
            case (kind)
                0, 1: begin
                    k = (n == 0) ? TO : (n == 1) ? 1 : $urandom_range(1, TO);
                    full_up(p, k);
                    go_to(cyc + $urandom_range(1, 10));
                    drop_lock(1'b1);
                end
                2: begin
                    push_ev(p + 3 + LS + TR, O_CKEW);
                    go_to(p + 37 + $urandom_range(0, 49));
                    drop_lock(1'b1);
                end
                3: begin
                    push_ev(p + 3 + LS + TR, O_CKEW);
                    push_ev(p + 89, O_INIT);
                    go_to(p + 87 + $urandom_range(0, 90));
                    drop_lock(1'b1);
                end
                default: begin
                    g = $urandom_range(1, 15);
                    go_to(p + g);
                    pll_lock = 1'b0;
                    go_to(p + g + 1);
                    pll_lock = 1'b1;
                    full_up(p + g + 1, $urandom_range(1, TO));
                    go_to(cyc + $urandom_range(1, 10));
                    drop_lock(1'b1);
                end
            endcase
        end
        // init timeout(s), with a stray ack just after the abort, then success
        p = cyc + 2;
        start_lock(p);
        i = p + 89;
        push_ev(p + 3 + LS + TR, O_CKEW);
        push_ev(i, O_INIT);
        nto = $urandom_range(1, 2);
        for (int t = 0; t < nto; t++) begin
            abort_cnt();
            push_ev(i + TO, O_NONE);
            push_ev(i + TO + TR, O_CKEW);
            push_ev(i + TO + TR + TC, O_INIT);
            go_to(i + TO);
            init_ack = 1'b1;
            go_to(i + TO + 1);
            init_ack = 1'b0;
            i = i + TO + TR + TC;
        end
        ack_at(i, $urandom_range(1, TO));
        go_to(cyc + 5);
        // sync reset mid-CKE_WAIT with lock held: sequence restarts from WAIT_LOCK
        go_to(cyc + $urandom_range(1, 10));
        drop_lock(1'b1);
        p = cyc + 2;
        start_lock(p);
        push_ev(p + 3 + LS + TR, O_CKEW);
        go_to(p + 39 + $urandom_range(1, 40));
        reset_dut(1'b1, p);
        full_up(p, $urandom_range(1, TO));
        go_to(cyc + 3);
        // saturate restart_cnt with lock losses during RST_LOW
        reset_dut(1'b0, p);
        for (int a = 0; a < 260; a++) begin
            p = cyc + 1;
            start_lock(p);
            go_to(p + 17 + $urandom_range(0, 19));
            drop_lock(1'b1);
        end
        go_to(cyc + 4);
        @(negedge clk);
        check_now("restart_cnt_sat", {5'b00000, restart_cnt}, {O_NONE, 8'd255});
        go_to(cyc + 2);
        done = 1'b1;
    endtask

    initial begin
        resetn   = 1'b0;
        pll_lock = 1'b0;
        init_ack = 1'b0;
        exp_last = 13'd0;
        m_rc     = 8'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check_now("reset_state", outs(), 13'd0);
        go_to(cyc + 1);
        fork
            monitor();
            stimulus();
        join
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events got=%0d pending want=0 (next cyc=%0d)",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
